bc_decoder: RTL and testbench

BC_DECODER -- requirements
Module: bc_decoder

---
 rtl/bc_pkg.sv | 15 +
 rtl/bc_sync_edge.sv | 32 +++
 rtl/bc_decoder.sv | 177 +++++++++++++++++
 tb/tb_bc_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// rtl/bc_pkg.sv - shared state type and default sizes for the barcode decoder
package bc_pkg;

    localparam int ID_W_DEF  = 8;
    localparam int CHK_W_DEF = 2;
    localparam int TMR_W_DEF = 22;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_FALL = 2'd2,
        WAIT_SMP  = 2'd3
    } bc_state_t;

endpackage

// File: rtl/bc_sync_edge.sv
// rtl/bc_sync_edge.sv - two-flop synchroniser for the barcode line plus rise/fall detect
module bc_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic bc,
    output logic level,
    output logic fall,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    // Flops come out of reset at the idle-high level so release never looks like a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= bc;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level = s2;
    assign fall  = prev & ~s2;
    assign rise  = ~prev & s2;

endmodule

// File: rtl/bc_decoder.sv
// rtl/bc_decoder.sv - barcode station-ID decoder (pulse-width bits, MSB first)
// Define BC_TIMEOUT_EN to abort stalled frames in START/WAIT_FALL.
module bc_decoder
    import bc_pkg::*;
#(
    parameter int ID_W  = ID_W_DEF,
    parameter int CHK_W = CHK_W_DEF,
    parameter int TMR_W = TMR_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            BC,
    input  logic            clr_ID_vld,
    output logic [ID_W-1:0] ID,
    output logic            ID_vld,
    output logic            busy,
    output logic            frm_err
);

    localparam int                CNT_W    = $clog2(ID_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ID_W);
    localparam logic [TMR_W-1:0]  TMR_MAX  = '1;
    localparam logic [ID_W-1:0]   CHK_MASK = ~({ID_W{1'b1}} >> CHK_W);

    bc_state_t        state;
    bc_state_t        state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_inc;
    logic [TMR_W-1:0] half_per;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [ID_W-2:0]  shreg;
    logic [ID_W-1:0]  sh_nxt;
    logic             frame_ok;

    logic level;
    logic fall;
    logic rise;

    logic tmr_clr;
    logic tmr_inc;
    logic cnt_clr;
    logic hp_ld;
    logic do_smp;
    logic frm_done;
    logic abort;

    bc_sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .bc    (BC),
        .level (level),
        .fall  (fall),
        .rise  (rise)
    );

    assign timer_inc = (timer == TMR_MAX) ? timer : timer + TMR_W'(1);
    assign cnt_nxt   = bit_cnt + CNT_W'(1);
    assign sh_nxt    = {shreg, level};
    assign frame_ok  = (sh_nxt & CHK_MASK) == '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        cnt_clr   = 1'b0;
        hp_ld     = 1'b0;
        do_smp    = 1'b0;
        frm_done  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    tmr_clr   = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (rise) begin
                    hp_ld     = 1'b1;
                    state_nxt = WAIT_FALL;
                end
`ifdef BC_TIMEOUT_EN
                else if (timer == TMR_MAX) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
`endif
                else begin
                    tmr_inc = 1'b1;
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    tmr_clr   = 1'b1;
                    state_nxt = WAIT_SMP;
                end
`ifdef BC_TIMEOUT_EN
                else if ({2'b00, timer} >= {half_per, 2'b00}) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
`endif
                else begin
                    tmr_inc = 1'b1;
                end
            end
            WAIT_SMP: begin
                // Falls before the sample point are deliberately ignored here.
                if (timer == half_per) begin
                    do_smp = 1'b1;
                    if (cnt_nxt != CNT_LAST) begin
                        state_nxt = WAIT_FALL;
                    end else begin
                        frm_done  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            half_per <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ID       <= '0;
            ID_vld   <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            if (tmr_clr) begin
                timer <= '0;
            end else if (tmr_inc) begin
                timer <= timer_inc;
            end
            if (cnt_clr) begin
                bit_cnt <= '0;
            end
            if (hp_ld) begin
                half_per <= (timer == '0) ? TMR_W'(1) : timer;
            end
            if (do_smp) begin
                shreg   <= sh_nxt[ID_W-2:0];
                bit_cnt <= cnt_nxt;
            end
            if (frm_done && frame_ok) begin
                ID <= sh_nxt;
            end
            if ((frm_done && !frame_ok) || abort) begin
                frm_err <= 1'b1;
            end
            // A new valid frame outranks a simultaneous consumer clear.
            if (frm_done && frame_ok) begin
                ID_vld <= 1'b1;
            end else if (clr_ID_vld) begin
                ID_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bc_decoder.sv
// tb/tb_bc_decoder.sv - directed bench for bc_decoder (8-bit default and 12-bit instances)
module tb_bc_decoder;

    localparam int PER  = 522;
    localparam int HALF = 261;
    localparam int LAT  = 264;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bc_a, bc_b;
    logic        clr_a, clr_b;
    logic [7:0]  id_a;
    logic [11:0] id_b;
    logic        vld_a, vld_b, busy_a, busy_b, err_a, err_b;

    int checks = 0;
    int errors = 0;
    int errs_a = 0;
    int errs_b = 0;
    int lat;

    always #5 clk = ~clk;

    bc_decoder u_a (
        .clk(clk), .rst_n(rst_n), .BC(bc_a), .clr_ID_vld(clr_a),
        .ID(id_a), .ID_vld(vld_a), .busy(busy_a), .frm_err(err_a)
    );

    bc_decoder #(.ID_W(12), .CHK_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .BC(bc_b), .clr_ID_vld(clr_b),
        .ID(id_b), .ID_vld(vld_b), .busy(busy_b), .frm_err(err_b)
    );

    always @(negedge clk) begin
        if (err_a) errs_a++;
        if (err_b) errs_b++;
    end

    // Start cell (half low, half high) then nbits cells; a 1 is a short low, a 0 a long low.
    task automatic send_frame(input int sel, input logic [15:0] val, input int nbits, input int clr_at);
        int low;
        lat = -1;
        for (int c = 0; c < PER; c++) begin
            @(negedge clk);
            if (sel == 0) bc_a = (c >= HALF); else bc_b = (c >= HALF);
        end
        for (int i = nbits - 1; i >= 0; i--) begin
            low = val[i] ? 130 : 391;
            for (int c = 0; c < PER; c++) begin
                @(negedge clk);
                if (i == 0 && lat < 0 && ((sel == 0) ? vld_a : vld_b)) lat = c;
                if (sel == 0) bc_a = (c >= low); else bc_b = (c >= low);
                if (sel == 0 && i == 0) clr_a = (c == clr_at);
            end
        end
        clr_a = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bc_a = 1'b1; bc_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({id_a, vld_a, busy_a, err_a} !== 11'd0) begin
            errors++; $display("FAIL reset_a: got %0h expected 0", {id_a, vld_a, busy_a, err_a});
        end
        checks++;
        if ({id_b, vld_b, busy_b, err_b} !== 15'd0) begin
            errors++; $display("FAIL reset_b: got %0h expected 0", {id_b, vld_b, busy_b, err_b});
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || errs_a != 0) begin
            errors++; $display("FAIL release_idle: got busy=%0b errs=%0d expected busy=0 errs=0", busy_a, errs_a);
        end
    endtask

    task automatic test_basic;
        send_frame(0, 16'h10, 8, -1);
        checks++;
        if (lat != LAT) begin
            errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (id_a !== 8'h10) begin
            errors++; $display("FAIL basic_id: got %0h expected 10", id_a);
        end
        checks++;
        if (vld_a !== 1'b1 || errs_a != 0) begin
            errors++; $display("FAIL basic_flags: got vld=%0b errs=%0d expected vld=1 errs=0", vld_a, errs_a);
        end
    endtask

    task automatic test_invalid;
        send_frame(0, 16'h50, 8, -1);
        checks++;
        if (errs_a != 1 || id_a !== 8'h10) begin
            errors++; $display("FAIL reject_50: got errs=%0d id=%0h expected errs=1 id=10", errs_a, id_a);
        end
        send_frame(0, 16'h35, 8, -1);
        checks++;
        if (id_a !== 8'h35 || vld_a !== 1'b1 || errs_a != 1) begin
            errors++; $display("FAIL accept_35: got id=%0h vld=%0b errs=%0d expected 35/1/1", id_a, vld_a, errs_a);
        end
        send_frame(0, 16'h90, 8, -1);
        checks++;
        if (errs_a != 2) begin
            errors++; $display("FAIL reject_90_pulse: got errs=%0d expected 2", errs_a);
        end
        checks++;
        if (id_a !== 8'h35 || vld_a !== 1'b1) begin
            errors++; $display("FAIL reject_90_hold: got id=%0h vld=%0b expected 35/1", id_a, vld_a);
        end
    endtask

    task automatic test_set_clr_collision;
        send_frame(0, 16'h25, 8, LAT - 1);
        checks++;
        if (id_a !== 8'h25 || vld_a !== 1'b1) begin
            errors++; $display("FAIL set_wins: got id=%0h vld=%0b expected 25/1", id_a, vld_a);
        end
        @(negedge clk); clr_a = 1'b1;
        @(negedge clk); clr_a = 1'b0;
        checks++;
        if (vld_a !== 1'b0) begin
            errors++; $display("FAIL clr_only: got vld=%0b expected 0", vld_a);
        end
    endtask

    task automatic test_reset_mid_frame;
        send_frame(0, 16'h5, 3, -1);
        @(negedge clk); bc_a = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (id_a !== 8'h00 || vld_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL async_reset: got id=%0h vld=%0b busy=%0b expected 0/0/0", id_a, vld_a, busy_a);
        end
        bc_a = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(0, 16'h2A, 8, -1);
        checks++;
        if (id_a !== 8'h2A || vld_a !== 1'b1 || errs_a != 2) begin
            errors++; $display("FAIL after_reset: got id=%0h vld=%0b errs=%0d expected 2a/1/2", id_a, vld_a, errs_a);
        end
    endtask

    task automatic test_timeout;
        send_frame(0, 16'hA, 4, -1);
        repeat (1500) @(negedge clk);
`ifdef BC_TIMEOUT_EN
        checks++;
        if (busy_a !== 1'b0 || errs_a != 3) begin
            errors++; $display("FAIL timeout_abort: got busy=%0b errs=%0d expected 0/3", busy_a, errs_a);
        end
`else
        checks++;
        if (busy_a !== 1'b1 || errs_a != 2) begin
            errors++; $display("FAIL no_timeout: got busy=%0b errs=%0d expected 1/2", busy_a, errs_a);
        end
`endif
        checks++;
        if (id_a !== 8'h2A) begin
            errors++; $display("FAIL timeout_id: got %0h expected 2a", id_a);
        end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_wide;
        send_frame(1, 16'h0AB, 12, -1);
        checks++;
        if (id_b !== 12'h0AB || vld_b !== 1'b1 || errs_b != 0) begin
            errors++; $display("FAIL wide_0ab: got id=%0h vld=%0b errs=%0d expected 0ab/1/0", id_b, vld_b, errs_b);
        end
        send_frame(1, 16'h1AB, 12, -1);
        checks++;
        if (errs_b != 1 || id_b !== 12'h0AB) begin
            errors++; $display("FAIL wide_1ab: got errs=%0d id=%0h expected 1/0ab", errs_b, id_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_set_clr_collision();
        test_reset_mid_frame();
        test_timeout();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
